alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational RV32I `alu` between `NUM_REQ` requesters, e.g. the execute stage and the branch-target/PC-increment path in a multi-cycle core. Each requester uses a valid/ready handshake to submit operands and an op code. The arbiter registers the winning request, drives the ALU for one cycle and captures `alu_result`/`zero`/`last_bit`. It then returns the result to that requester through a valid/ready response channel. Grants are round-robin, so no requester starves.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..8.
- `XLEN`, 32: operand/result width. Must match the `alu`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: requester i has a request pending.
- `req_ready`  out  NUM_REQ: one-hot grant. A handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_src1`, `req_src2`  in  NUM_REQ×XLEN: per-requester operands, packed `[NUM_REQ-1:0][XLEN-1:0]`.
- `req_op`  in  NUM_REQ×4: per-requester `alu_control` code.
- `rsp_valid`  out  NUM_REQ: one-hot, result available for requester i.
- `rsp_ready`  in  NUM_REQ: requester i accepts the result.
- `rsp_result`  out  XLEN: captured `alu_result`, shared by all requesters.
- `rsp_zero`, `rsp_last_bit`  out  1: captured ALU flags.
- `alu_src1`, `alu_src2`  out  XLEN: drive the ALU operands.
- `alu_control`  out  4: drives the ALU op.
- `alu_result`  in  XLEN, `alu_zero`  in  1, `alu_last_bit`  in  1: ALU outputs, combinational from the `alu_*` drives.

## Operation
The FSM has three states: IDLE, EXEC, RESP.

IDLE
- The round-robin arbiter selects the first `req_valid` bit at or after pointer `rr_ptr`.
- `req_ready` is asserted combinationally for that index only.
- On handshake: latch src1, src2, op and the grant index. Set `rr_ptr = grant + 1`, wrapping modulo `NUM_REQ`. Go to EXEC.
- With no valid requests: `req_ready = 0` and the state stays IDLE.

EXEC
- `alu_src1`, `alu_src2` and `alu_control` come from the latched registers. Outside EXEC they are 0.
- At the clock edge, capture `alu_result`, `alu_zero` and `alu_last_bit` into the `rsp_*` registers. Go to RESP.

RESP
- `rsp_valid[grant] = 1`. Data is held stable until `rsp_ready[grant]`.
- On response handshake, go to IDLE.
- `rsp_ready` bits of non-granted requesters are ignored.

General rules
- `req_ready` is 0 in EXEC and RESP. Only one operation is in flight at a time.
- Op codes are passed through unchecked. Undefined codes give whatever the ALU produces; for example, 4'b1111 gives 0.
- A requester may deassert `req_valid` before it is granted without side effects.

## Timing
Reset values (asynchronous assertion of `rst_n = 0`):
- State is IDLE and `rr_ptr` is 0.
- All of `req_ready`, `rsp_valid`, `rsp_result`, `rsp_zero`, `rsp_last_bit`, `alu_src1`, `alu_src2` and `alu_control` are 0.

Latency:
- Request handshake in cycle N: EXEC in N+1, `rsp_valid` in N+2.
- The minimum issue interval is 3 cycles, when `rsp_ready` is already high in N+2.

Boundary conditions:
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response, and `rr_ptr` returns to 0.
- Simultaneous requests: the grant goes to the lowest index at or after `rr_ptr`.
- A requester that is still asserting `req_valid` while its own response is pending cannot be re-granted until the FSM returns to IDLE.
- Wrap-around: a grant to index `NUM_REQ-1` sets `rr_ptr` to 0.
- Deasserting `rst_n` takes effect at the next `clk` edge. Release must be synchronous to `clk` at system level.

## Structure
- The shared package `alu_pkg` holds `XLEN`, `ALU_OP_W = 4`, and the enum `alu_op_e` (ALU_ADD = 4'b0000, etc.). The arbiter's state enum stays local to the module.
- Sub-module `rr_arbiter`: parameterised `NUM_REQ`, combinational. Inputs are `req` and `ptr`; outputs are a one-hot `grant` and an encoded `grant_idx`. The FSM, registers and response path stay in `alu_arbiter`.
- The `alu` itself is instantiated outside. The bench instantiates the real `alu` beside the arbiter.

## Test plan
- Reset mid-EXEC:
  - Stimulus: assert `rst_n = 0` while in EXEC.
  - Response: all outputs go to 0 immediately; no `rsp_valid` is ever seen; the next grant goes to index 0.
- Single ADD:
  - Stimulus: requester 0, op 4'b0000, 5 + 7.
  - Response: `req_ready[0]` in the same cycle; `rsp_valid[0]` 2 cycles later with `rsp_result = 12`, `rsp_zero = 0`.
- Zero flag:
  - Stimulus: requester 1 computes 12345 + (−12345).
  - Response: `rsp_result = 0`, `rsp_zero = 1`.
- Round-robin fairness:
  - Stimulus: both requesters hold `req_valid` for 6 operations, with `rsp_ready` tied high.
  - Response: grants alternate 0, 1, 0, 1, 0, 1; each requester's results match its own operands.
- Backpressure:
  - Stimulus: `rsp_ready[0] = 0` for 5 cycles.
  - Response: `rsp_valid[0]` and `rsp_result` stay stable; `req_ready` stays 0 for all requesters until the handshake.
- Default op:
  - Stimulus: op 4'b1111 with random operands.
  - Response: `rsp_result = 0`.
  - Also: 1000 random ADD operations across 3 requesters (`NUM_REQ = 3`) all match a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg -- shared ALU operand width and op-code encoding.   Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter_if -- requester request/response channels.   Rev 1.0
// ---------------------------------------------------------------------------
interface alu_arbiter_if import alu_pkg::*; #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][XLEN-1:0]      req_src1;
  logic [NUM_REQ-1:0][XLEN-1:0]      req_src2;
  logic [NUM_REQ-1:0][ALU_OP_W-1:0]  req_op;
  logic [NUM_REQ-1:0]                rsp_valid;
  logic [NUM_REQ-1:0]                rsp_ready;
  logic [XLEN-1:0]                   rsp_result;
  logic                              rsp_zero;
  logic                              rsp_last_bit;

  modport master (
    output req_valid, req_src1, req_src2, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_last_bit
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_last_bit
  );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu -- combinational RV32I ALU shared through alu_arbiter.   Rev 1.0
// ---------------------------------------------------------------------------
module alu import alu_pkg::*; (
  input  logic [XLEN-1:0]     src1_i,
  input  logic [XLEN-1:0]     src2_i,
  input  logic [ALU_OP_W-1:0] alu_control_i,
  output logic [XLEN-1:0]     alu_result_o,
  output logic                zero_o,
  output logic                last_bit_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = src2_i[SHW-1:0];

  always_comb begin
    alu_result_o = '0;
    case (alu_control_i)
      ALU_ADD:  alu_result_o = src1_i + src2_i;
      ALU_SUB:  alu_result_o = src1_i - src2_i;
      ALU_AND:  alu_result_o = src1_i & src2_i;
      ALU_OR:   alu_result_o = src1_i | src2_i;
      ALU_XOR:  alu_result_o = src1_i ^ src2_i;
      ALU_SLL:  alu_result_o = src1_i << shamt;
      ALU_SRL:  alu_result_o = src1_i >> shamt;
      ALU_SRA:  alu_result_o = $unsigned($signed(src1_i) >>> shamt);
      ALU_SLT:  alu_result_o = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_SLTU: alu_result_o = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
      default:  alu_result_o = '0;
    endcase
  end

  assign zero_o     = (alu_result_o == '0);
  assign last_bit_o = alu_result_o[0];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin pick starting at ptr.   Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  int               slot;
  logic [IDX_W-1:0] slot_idx;

  // Walk the requesters starting at ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    slot        = 0;
    slot_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(ptr_i) + k;
      if (slot >= NUM_REQ) begin
        slot = slot - NUM_REQ;
      end
      slot_idx = IDX_W'(slot);
      if (!found && req_i[slot_idx]) begin
        found             = 1'b1;
        grant_o[slot_idx] = 1'b1;
        grant_idx_o       = slot_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter -- round-robin sharing of one ALU between NUM_REQ requesters.
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = alu_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_arbiter_if.slave         bus,
  output logic [XLEN-1:0]      alu_src1_o,
  output logic [XLEN-1:0]      alu_src2_o,
  output logic [ALU_OP_W-1:0]  alu_control_o,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic                 alu_zero_i,
  input  logic                 alu_last_bit_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [XLEN-1:0]       src1_q, src1_d;
  logic [XLEN-1:0]       src2_q, src2_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  lb_q, lb_d;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      lb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      lb_q     <= lb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    idx_d         = idx_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    op_d          = op_q;
    result_d      = result_q;
    zero_d        = zero_q;
    lb_d          = lb_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    alu_src1_o    = '0;
    alu_src2_o    = '0;
    alu_control_o = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = grant;
        if (|(bus.req_valid & grant)) begin
          src1_d   = bus.req_src1[grant_idx];
          src2_d   = bus.req_src2[grant_idx];
          op_d     = bus.req_op[grant_idx];
          idx_d    = grant_idx;
          rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src1_o    = src1_q;
        alu_src2_o    = src2_q;
        alu_control_o = op_q;
        result_d      = alu_result_i;
        zero_d        = alu_zero_i;
        lb_d          = alu_last_bit_i;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's rsp_ready can retire the response.
        bus.rsp_valid[idx_q] = 1'b1;
        if (bus.rsp_ready[idx_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_last_bit = lb_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_arbiter -- self-checking bench for alu_arbiter with the real alu.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N)) bus ();

  logic [XLEN-1:0]     alu_a, alu_b, alu_y;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_z, alu_lb;

  alu_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .alu_src1_o     (alu_a),
    .alu_src2_o     (alu_b),
    .alu_control_o  (alu_op),
    .alu_result_i   (alu_y),
    .alu_zero_i     (alu_z),
    .alu_last_bit_i (alu_lb)
  );

  alu u_alu (
    .src1_i        (alu_a),
    .src2_i        (alu_b),
    .alu_control_i (alu_op),
    .alu_result_o  (alu_y),
    .zero_o        (alu_z),
    .last_bit_o    (alu_lb)
  );

  typedef struct {
    int          req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        lb;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 0);
    chk({tag, "_rsp_flags"}, {bus.rsp_zero, bus.rsp_last_bit}, 0);
    chk({tag, "_alu_ops"}, {alu_a, alu_b}, 0);
    chk({tag, "_alu_ctl"}, alu_op, 0);
  endtask

  // Single isolated transaction with full latency checking.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.req_valid         = oh(v.req);
    bus.req_src1[v.req]   = v.a;
    bus.req_src2[v.req]   = v.b;
    bus.req_op[v.req]     = v.op;
    #1 chk({tag, "_grant"}, bus.req_ready, oh(v.req));
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk({tag, "_exec_ctl"}, alu_op, v.op);
    chk({tag, "_exec_rdy"}, {bus.req_ready, bus.rsp_valid}, 0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, oh(v.req));
    chk({tag, "_result"}, bus.rsp_result, v.res);
    chk({tag, "_flags"}, {bus.rsp_zero, bus.rsp_last_bit}, {v.z, v.lb});
    bus.rsp_ready = oh(v.req);
    @(negedge clk);
    bus.rsp_ready = '0;
    chk({tag, "_rsp_done"}, bus.rsp_valid, 0);
    ptr_m = (v.req + 1) % N;
  endtask

  initial begin
    logic [N-1:0]  pend;
    logic [31:0]   pa[N];
    logic [31:0]   pb[N];
    logic [31:0]   exp_r;
    logic [N-1:0]  rdy;
    int            g;
    int            d;
    vec_t          v;

    tbl[0]  = '{0, 4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    tbl[1]  = '{1, 4'b0000, 32'd12345,      32'hFFFF_CFC7,  32'd0,          1'b1, 1'b0};
    tbl[2]  = '{2, 4'b0001, 32'd10,         32'd3,          32'd7,          1'b0, 1'b1};
    tbl[3]  = '{0, 4'b0010, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F,  1'b0, 1'b1};
    tbl[4]  = '{1, 4'b0011, 32'h0000_1000,  32'h0000_0011,  32'h0000_1011,  1'b0, 1'b1};
    tbl[5]  = '{2, 4'b0100, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555,  1'b0, 1'b1};
    tbl[6]  = '{0, 4'b0101, 32'd1,          32'd4,          32'd16,         1'b0, 1'b0};
    tbl[7]  = '{1, 4'b0110, 32'h8000_0000,  32'd31,         32'd1,          1'b0, 1'b1};
    tbl[8]  = '{2, 4'b0111, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0};
    tbl[9]  = '{0, 4'b1000, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b1};
    tbl[10] = '{1, 4'b1001, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    tbl[11] = '{2, 4'b1111, 32'd1234,       32'd5678,       32'd0,          1'b1, 1'b0};

    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.req_op    = '0;

    // Reset state
    #2 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed op table
    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Default op with random operands
    for (int i = 0; i < 4; i++) begin
      v = '{int'($urandom_range(0, N - 1)), 4'b1111, $urandom, $urandom, 32'd0, 1'b1, 1'b0};
      run_vec(v, "defop");
    end

    // Reset while in EXEC: no response, pointer back to 0
    reset_dut();
    run_vec(tbl[0], "pre_rst");
    @(negedge clk);
    bus.req_valid   = 3'b010;
    bus.req_src1[1] = 32'h11;
    bus.req_src2[1] = 32'h22;
    bus.req_op[1]   = 4'b0000;
    #1 chk("rst_pre_grant", bus.req_ready, 3'b010);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("rst_pre_exec", alu_a, 32'h11);
    rst_n = 1'b0;
    #1 check_all_zero("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 0);
    end
    bus.req_valid   = 3'b101;
    bus.req_src1[0] = 32'd40;
    bus.req_src2[0] = 32'd2;
    bus.req_op[0]   = 4'b0000;
    bus.req_src1[2] = 32'd99;
    bus.req_src2[2] = 32'd1;
    bus.req_op[2]   = 4'b0000;
    #1 chk("rst_next_grant", bus.req_ready, 3'b001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("rst_next_rsp", bus.rsp_valid, 3'b001);
    chk("rst_next_res", bus.rsp_result, 32'd42);
    bus.rsp_ready = 3'b001;
    @(negedge clk);
    bus.rsp_ready = '0;
    ptr_m = 1;

    // Backpressure on requester 0 while others wait
    @(negedge clk);
    bus.req_valid   = 3'b001;
    bus.req_src1[0] = 32'h1234_0000;
    bus.req_src2[0] = 32'h0000_5678;
    bus.req_op[0]   = 4'b0011;
    @(negedge clk);
    bus.req_valid   = 3'b110;
    ptr_m = 1;
    #1 chk("bp_exec_rdy", bus.req_ready, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus.rsp_ready = 3'b110;
      #1 chk("bp_rsp_valid", bus.rsp_valid, 3'b001);
      chk("bp_result", bus.rsp_result, 32'h1234_5678);
      chk("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 3'b001;
    @(negedge clk);
    bus.rsp_ready = '0;
    #1 chk("bp_next_grant", bus.req_ready, oh(rr_pick(3'b110, ptr_m)));
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_withdraw", bus.req_ready, 0);
    v = '{2, 4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1};
    run_vec(v, "post_withdraw");

    // Round-robin fairness between requesters 0 and 1
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      bus.req_src1[i] = $urandom;
      bus.req_src2[i] = $urandom;
      bus.req_op[i]   = 4'b0000;
    end
    bus.req_valid = 3'b011;
    bus.rsp_ready = 3'b011;
    for (int k = 0; k < 6; k++) begin
      #1;
      g = rr_pick(3'b011, ptr_m);
      chk("rr_grant", bus.req_ready, oh(k % 2));
      exp_r = bus.req_src1[g] + bus.req_src2[g];
      ptr_m = (g + 1) % N;
      @(negedge clk);
      bus.req_src1[g] = $urandom;
      bus.req_src2[g] = $urandom;
      @(negedge clk);
      chk("rr_rsp_valid", bus.rsp_valid, oh(g));
      chk("rr_result", bus.rsp_result, exp_r);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;

    // Random ADD stress against the transaction-level model
    reset_dut();
    pend = '0;
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pa[i]   = $urandom;
          pb[i]   = $urandom;
        end
      end
      if (pend == '0) begin
        g       = $urandom_range(0, N - 1);
        pend[g] = 1'b1;
        pa[g]   = $urandom;
        pb[g]   = $urandom;
      end
      for (int i = 0; i < N; i++) begin
        bus.req_src1[i] = pa[i];
        bus.req_src2[i] = pb[i];
        bus.req_op[i]   = 4'b0000;
      end
      bus.req_valid = pend;
      #1;
      g = rr_pick(pend, ptr_m);
      chk("rnd_grant", bus.req_ready, oh(g));
      exp_r = ref_alu(4'b0000, pa[g], pb[g]);
      @(negedge clk);
      pend[g]       = 1'b0;
      bus.req_valid = pend;
      ptr_m         = (g + 1) % N;
      #1 chk("rnd_exec_rdy", bus.req_ready, 0);
      d = $urandom_range(0, 3);
      @(negedge clk);
      for (int c = 0; c <= d; c++) begin
        chk("rnd_rsp_valid", bus.rsp_valid, oh(g));
        chk("rnd_result", bus.rsp_result, exp_r);
        chk("rnd_zero", bus.rsp_zero, (exp_r == 32'd0));
        rdy           = N'($urandom);
        rdy[g]        = (c == d);
        bus.rsp_ready = rdy;
        if (c < d) @(negedge clk);
      end
      @(negedge clk);
      bus.rsp_ready = '0;
    end
    bus.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
